sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Input conditioner for the five board slide switches.
- Synchronises each raw, asynchronous switch into the clk domain and debounces it independently.
- Drives a clean, registered 5-bit level straight into the in[4:0] port of the combinational-function lab stage.
- Also produces per-bit rise/fall pulses and an aggregate change strobe for any later capture/display logic.

Parameters:
- WIDTH, 5, number of switch bits conditioned.
- SYNC_STAGES, 2, flip-flops in each bit's synchroniser chain; legal values are 2 or more.
- DB_CYCLES, 16, consecutive clk cycles a synchronised bit must differ from sw_out before sw_out follows it; legal values are 2 or more.
- The counter width is derived internally as clog2(DB_CYCLES); it is not a user parameter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sw_in  input  WIDTH  raw switch levels, asynchronous to clk.
- sw_out  output  WIDTH  debounced, registered switch levels; connects to the function stage's in[4:0].
- rise  output  WIDTH  one-cycle pulse per bit when that sw_out bit goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when that sw_out bit goes 1->0.
- change  output  1  one-cycle pulse, equal to OR over (rise | fall).

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low (rst_n sampled on the rising edge of clk). While rst_n=0 at an edge:
  - all synchroniser flops, all per-bit counters, sw_out, rise, fall and change load 0.
  - Reset overrides every other event in that cycle.
- Synchroniser:
  - sw_in[i] passes through SYNC_STAGES flops; the last stage is s[i].
  - No logic is placed between synchroniser stages.
- Per-bit debounce (bits fully independent, one counter cnt[i] each). At each edge, with rst_n=1:
  - s[i]==sw_out[i]: cnt[i] <- 0 and no pulse.
  - s[i]!=sw_out[i] and cnt[i]<DB_CYCLES-1: cnt[i] <- cnt[i]+1.
  - s[i]!=sw_out[i] and cnt[i]==DB_CYCLES-1: sw_out[i] <- s[i], cnt[i] <- 0, and rise[i] or fall[i] <- 1 according to direction.
- Pulses:
  - rise, fall and change are registered and high for exactly one cycle, in the same cycle the new sw_out value first appears.
  - Otherwise they are 0.
- Latency:
  - Let sw_in change before edge E0 and stay stable.
  - s updates at E(SYNC_STAGES-1).
  - sw_out updates at E(SYNC_STAGES+DB_CYCLES-1), i.e. on the (SYNC_STAGES+DB_CYCLES)-th edge. With defaults this is the 18th edge.
- Glitch rejection:
  - Any excursion of s[i] lasting fewer than DB_CYCLES cycles clears cnt[i] when s[i] returns.
  - sw_out is unchanged and no pulse is generated.
- Bounce:
  - Each return of s[i] to the sw_out value restarts the count from 0.
  - Settling is therefore measured from the last transition.
- Simultaneous events:
  - Several bits qualifying on the same edge update together.
  - rise/fall show all of them in one cycle; change is a single one-cycle pulse.
- Power-up with switches high:
  - sw_out starts at 0 after reset.
  - Bits that are high debounce upward normally and emit rise pulses (no special-casing).
- The counter never exceeds DB_CYCLES-1 and never wraps.
- No combinational path exists from sw_in to any output.

Test Plan:
1. Reset/power-up (defaults):
   - Stimulus: hold sw_in=5'b10110 and release rst_n before E0.
   - Required: sw_out=0 through E16; at E17 sw_out=10110, rise=10110, fall=0, change=1 for one cycle, then rise=0 and change=0.
2. Glitch:
   - Stimulus: with sw_out=0, drive sw_in[0]=1 for 10 cycles, then back to 0.
   - Required: sw_out stays 00000; rise, fall and change stay 0 throughout.
3. Bounce:
   - Stimulus: sw_in[4] toggles every 3 cycles for 30 cycles, then settles at 1.
   - Required: sw_out[4] rises exactly 18 edges after the final settle; exactly one rise[4] pulse.
4. Simultaneous:
   - Stimulus: from sw_out=00010, drive sw_in=01000 in one cycle (bit3 up, bit1 down).
   - Required: one cycle with rise=01000, fall=00010, change=1; sw_out=01000.
5. Reset mid-count:
   - Stimulus: sw_in=11111 stable for 10 cycles, then rst_n=0 for one edge, then released with sw_in unchanged.
   - Required: at the reset edge all outputs are 0; sw_out=11111 appears on the 18th edge after release, not earlier.
6. Parameter sweep:
   - Stimulus: SYNC_STAGES=3, DB_CYCLES=2 with a stable step on sw_in[2].
   - Required: sw_out[2] updates on the 5th edge; a 1-cycle glitch is rejected.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchroniser and debouncer for raw switches with registered rise/fall/change pulses
module sw_debounce #(
  parameter int WIDTH = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             change
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q, out_d, rise_q, rise_d, fall_q, fall_d, s, done;
  logic change_q, change_d;
  assign s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d[0] = sw_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end
  always_comb begin
    done = '0;
    cnt_d = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      done[i] = s[i] != out_q[i] && cnt_q[i] == CNT_MAX;
      cnt_d[i] = s[i] != out_q[i] && !done[i] ? cnt_q[i] + 1'b1 : '0;
    end
    out_d = out_q ^ done;
    rise_d = done & s;
    fall_d = done & ~s;
    change_d = |done;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
      cnt_q <= '{default: '0};
      out_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      change_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      change_q <= change_d;
    end
  end
  assign sw_out = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign change = change_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table vectors, corner sequences and randomized model comparison for sw_debounce
module tb_sw_debounce;
  localparam int W = 5;
  localparam int SS = 2;
  localparam int DB = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out, rise, fall;
  logic change;
  logic rst6_n = 1'b0;
  logic [W-1:0] sw6 = '0;
  logic [W-1:0] out6, rise6, fall6;
  logic chg6;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  sw_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
    .sw_out(sw_out), .rise(rise), .fall(fall), .change(change)
  );
  sw_debounce #(.WIDTH(W), .SYNC_STAGES(3), .DB_CYCLES(2)) u6 (
    .clk(clk), .rst_n(rst6_n), .sw_in(sw6),
    .sw_out(out6), .rise(rise6), .fall(fall6), .change(chg6)
  );
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic [W-1:0] m_s;
  int m_run [W];
  always @(posedge clk) begin
    if (!rst_n) begin
      m_hist = {};
      for (int i = 0; i < SS; i++) m_hist.push_front('0);
      m_out = '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_s = m_hist[SS-1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        m_run[i] = (m_s[i] != m_out[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == DB) begin
          m_out[i] = m_s[i];
          if (m_s[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
          m_run[i] = 0;
        end
      end
      m_hist.push_front(sw_in);
      void'(m_hist.pop_back());
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask
  task automatic step(input logic r, input logic [W-1:0] v);
    @(negedge clk);
    rst_n = r;
    sw_in = v;
    @(posedge clk);
    #1;
  endtask
  task automatic step6(input logic r, input logic [W-1:0] v);
    @(negedge clk);
    rst6_n = r;
    sw6 = v;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic r;
    logic [W-1:0] sw;
    int n;
    logic [W-1:0] out;
    logic [W-1:0] ri;
    logic [W-1:0] fa;
    logic ch;
  } vec_t;
  vec_t tbl [$];
  function automatic vec_t mk(logic r, logic [W-1:0] sw, int n, logic [W-1:0] out,
                              logic [W-1:0] ri, logic [W-1:0] fa, logic ch);
    vec_t v;
    v.r = r; v.sw = sw; v.n = n; v.out = out; v.ri = ri; v.fa = fa; v.ch = ch;
    return v;
  endfunction
  initial begin
    int rises, first, falls, len;
    logic [W-1:0] v, vc;
    logic r;
    tbl.push_back(mk(0, 5'b10110, 1,  5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b10110, 17, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b10110, 1,  5'b10110, 5'b10110, 5'b00000, 1));
    tbl.push_back(mk(1, 5'b10110, 2,  5'b10110, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(0, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00001, 10, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 20, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(0, 5'b00010, 1,  5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00010, 17, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00010, 1,  5'b00010, 5'b00010, 5'b00000, 1));
    tbl.push_back(mk(1, 5'b01000, 17, 5'b00010, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b01000, 1,  5'b01000, 5'b01000, 5'b00010, 1));
    tbl.push_back(mk(1, 5'b01000, 2,  5'b01000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b11111, 10, 5'b01000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(0, 5'b11111, 1,  5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b11111, 17, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b11111, 1,  5'b11111, 5'b11111, 5'b00000, 1));
    tbl.push_back(mk(1, 5'b11111, 1,  5'b11111, 5'b00000, 5'b00000, 0));
    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        step(tbl[k].r, tbl[k].sw);
        chk($sformatf("vec%0d.%0d sw_out", k, j), sw_out, tbl[k].out);
        chk($sformatf("vec%0d.%0d rise", k, j), rise, tbl[k].ri);
        chk($sformatf("vec%0d.%0d fall", k, j), fall, tbl[k].fa);
        chk($sformatf("vec%0d.%0d change", k, j), change, tbl[k].ch);
      end
    end
    step(0, '0);
    rises = 0;
    first = -1;
    for (int c = 0; c < 30; c++) begin
      step(1, ((c / 3) % 2 == 0) ? 5'b10000 : 5'b00000);
      if (rise[4]) rises++;
      chk($sformatf("bounce%0d sw_out", c), sw_out, 5'b00000);
    end
    for (int c = 0; c < 30; c++) begin
      step(1, 5'b10000);
      if (rise[4]) rises++;
      if (sw_out[4] && first < 0) first = c;
    end
    chk("bounce rise count", rises, 1);
    chk("bounce settle edge", first, 17);
    chk("bounce final sw_out", sw_out, 5'b10000);
    step6(0, '0);
    for (int c = 0; c < 4; c++) begin
      step6(1, 5'b00100);
      chk($sformatf("p6 pre%0d sw_out", c), out6, 5'b00000);
    end
    step6(1, 5'b00100);
    chk("p6 edge5 sw_out", out6, 5'b00100);
    chk("p6 edge5 rise", rise6, 5'b00100);
    chk("p6 edge5 change", chg6, 1);
    falls = 0;
    step6(1, 5'b00000);
    for (int c = 0; c < 8; c++) begin
      step6(1, 5'b00100);
      if (fall6[2]) falls++;
      chk($sformatf("p6 glitch%0d sw_out", c), out6, 5'b00100);
    end
    chk("p6 glitch falls", falls, 0);
    step(0, '0);
    for (int n = 0; n < 4000;) begin
      v = W'($urandom);
      len = $urandom_range(1, 40);
      r = ($urandom_range(0, 49) != 0);
      if (!r) len = 1;
      for (int j = 0; j < len; j++) begin
        vc = ($urandom_range(0, 9) == 0) ? v ^ W'($urandom) : v;
        step(r, vc);
        chk("rnd sw_out", sw_out, m_out);
        chk("rnd rise", rise, m_rise);
        chk("rnd fall", fall, m_fall);
        chk("rnd change", change, |(m_rise | m_fall));
        n++;
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
